// File: rtl/motor_cmd_seq.sv
// motor_cmd_seq: arming, slew-limiting and disarm ramp-down sequencer feeding the ESC block
module motor_cmd_seq #(
  parameter int          WRT_PERIOD = 50000,
  parameter int          ARM_WRTS   = 1000,
  parameter logic [10:0] MAX_STEP   = 11'd16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] frnt_cmd,
  input  logic [10:0] bck_cmd,
  input  logic [10:0] lft_cmd,
  input  logic [10:0] rght_cmd,
  input  logic        arm,
  output logic [10:0] frnt_spd,
  output logic [10:0] bck_spd,
  output logic [10:0] lft_spd,
  output logic [10:0] rght_spd,
  output logic        wrt,
  output logic        motors_off,
  output logic        armed
);
  localparam int CW = $clog2(WRT_PERIOD);
  localparam int AW = $clog2(ARM_WRTS + 1);
  typedef enum logic [1:0] {OFF, ARMING, RUN, STOP} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] arm_cnt_q, arm_cnt_d;
  logic [3:0][10:0] cmd, spd_q, spd_d, slew, ramp, diff, step;
  logic tick;
  assign cmd = {rght_cmd, lft_cmd, bck_cmd, frnt_cmd};
  assign tick = cnt_q == CW'(WRT_PERIOD - 1);
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;
  assign {rght_spd, lft_spd, bck_spd, frnt_spd} = spd_q;
  // Difference is taken larger-minus-smaller so slewing never wraps past 0 or 2047
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      diff[i] = cmd[i] > spd_q[i] ? cmd[i] - spd_q[i] : spd_q[i] - cmd[i];
      step[i] = diff[i] < MAX_STEP ? diff[i] : MAX_STEP;
      slew[i] = cmd[i] > spd_q[i] ? spd_q[i] + step[i] : spd_q[i] - step[i];
      ramp[i] = spd_q[i] - (spd_q[i] < MAX_STEP ? spd_q[i] : MAX_STEP);
    end
  end
  always_comb begin
    state_d = state_q;
    arm_cnt_d = arm_cnt_q;
    spd_d = spd_q;
    if (tick) begin
      case (state_q)
        OFF: if (arm) begin
          state_d = ARMING;
          arm_cnt_d = '0;
        end
        ARMING: if (!arm) state_d = OFF;
          else if (arm_cnt_q == AW'(ARM_WRTS - 1)) begin
            state_d = RUN;
            spd_d = slew;
          end else arm_cnt_d = arm_cnt_q + 1'b1;
        RUN: if (!arm) state_d = STOP;
          else spd_d = slew;
        default: if (arm) state_d = RUN;
          else if (spd_q == '0) state_d = OFF;
          else spd_d = ramp;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OFF;
      cnt_q <= '0;
      arm_cnt_q <= '0;
      spd_q <= '0;
      wrt <= 1'b0;
      motors_off <= 1'b1;
      armed <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      arm_cnt_q <= arm_cnt_d;
      spd_q <= spd_d;
      wrt <= tick;
      motors_off <= state_d == OFF;
      armed <= state_d == RUN;
    end
  end
endmodule

// File: tb/tb_motor_cmd_seq.sv
// tb_motor_cmd_seq: directed scenarios plus random arm/command traffic checked against a tick-level reference model
module tb_motor_cmd_seq;
  localparam int P = 8;
  localparam int AWR = 3;
  localparam int STP = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic arm = 1'b0;
  logic [10:0] frnt_cmd = '0, bck_cmd = '0, lft_cmd = '0, rght_cmd = '0;
  logic [10:0] frnt_spd, bck_spd, lft_spd, rght_spd;
  logic wrt, motors_off, armed;
  int n_tests = 0;
  int n_fail = 0;
  int k = 0;
  int m_mode = 0;
  int m_ticks = 0;
  int m_spd[4] = '{0, 0, 0, 0};

  motor_cmd_seq #(.WRT_PERIOD(P), .ARM_WRTS(AWR), .MAX_STEP(11'(STP))) dut (
    .clk(clk), .rst_n(rst_n),
    .frnt_cmd(frnt_cmd), .bck_cmd(bck_cmd), .lft_cmd(lft_cmd), .rght_cmd(rght_cmd),
    .arm(arm),
    .frnt_spd(frnt_spd), .bck_spd(bck_spd), .lft_spd(lft_spd), .rght_spd(rght_spd),
    .wrt(wrt), .motors_off(motors_off), .armed(armed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Reference: modes 0=off 1=arming 2=run 3=stop, updated once per update period
  task automatic model_tick(input bit a, input int c0, input int c1, input int c2, input int c3);
    int c[4];
    int s;
    c = '{c0, c1, c2, c3};
    s = m_spd[0] + m_spd[1] + m_spd[2] + m_spd[3];
    if (m_mode == 0) begin
      if (a) begin m_mode = 1; m_ticks = 0; end
    end else if (m_mode == 1) begin
      if (!a) m_mode = 0;
      else if (++m_ticks == AWR) m_mode = 2;
    end else if (m_mode == 2) begin
      if (!a) m_mode = 3;
    end else begin
      if (a) m_mode = 2;
      else if (s == 0) m_mode = 0;
      else for (int i = 0; i < 4; i++) m_spd[i] = m_spd[i] > STP ? m_spd[i] - STP : 0;
    end
    if (m_mode == 2 && a && !(m_ticks == AWR && s < 0))
      if (!(m_mode == 2 && m_ticks == -1)) ;
  endtask

  task automatic model_slew(input int c0, input int c1, input int c2, input int c3);
    int c[4];
    int d;
    c = '{c0, c1, c2, c3};
    for (int i = 0; i < 4; i++) begin
      d = c[i] - m_spd[i];
      if (d > STP) d = STP;
      if (d < -STP) d = -STP;
      m_spd[i] += d;
    end
  endtask

  always @(negedge rst_n) begin
    m_mode = 0;
    m_ticks = 0;
    m_spd = '{0, 0, 0, 0};
    k = 0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      int prev;
      bit a;
      int c0, c1, c2, c3;
      k++;
      a = arm;
      c0 = int'(frnt_cmd); c1 = int'(bck_cmd); c2 = int'(lft_cmd); c3 = int'(rght_cmd);
      if (k % P == 0) begin
        prev = m_mode;
        model_tick(a, c0, c1, c2, c3);
        if (a && m_mode == 2 && (prev == 2 || prev == 1)) model_slew(c0, c1, c2, c3);
      end
      #1;
      if (rst_n) begin
        chk("wrt", 16'(wrt), 16'(k % P == 0));
        chk("motors_off", 16'(motors_off), 16'(m_mode == 0));
        chk("armed", 16'(armed), 16'(m_mode == 2));
        chk("frnt_spd", 16'(frnt_spd), 16'(m_spd[0]));
        chk("bck_spd", 16'(bck_spd), 16'(m_spd[1]));
        chk("lft_spd", 16'(lft_spd), 16'(m_spd[2]));
        chk("rght_spd", 16'(rght_spd), 16'(m_spd[3]));
      end
    end
  end

  task automatic ticks(input int n);
    repeat (n * P) @(negedge clk);
  endtask

  task automatic set_cmds(input int a, input int b, input int c, input int d);
    frnt_cmd = 11'(a); bck_cmd = 11'(b); lft_cmd = 11'(c); rght_cmd = 11'(d);
  endtask

  function automatic int rnd_cmd();
    int r;
    r = int'($urandom_range(0, 9));
    return r == 0 ? 0 : r == 1 ? 2047 : int'($urandom_range(0, 2047));
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_wrt", 16'(wrt), 16'd0);
    chk("rst_motors_off", 16'(motors_off), 16'd1);
    chk("rst_armed", 16'(armed), 16'd0);
    chk("rst_spd", 16'(frnt_spd | bck_spd | lft_spd | rght_spd), 16'd0);
    rst_n = 1'b1;
    ticks(4);
    set_cmds(400, 400, 400, 400);
    arm = 1'b1;
    ticks(AWR + 1 + 25 + 3);
    chk("ramp_reached", 16'(frnt_spd), 16'd400);
    set_cmds(390, 2047, 400, 400);
    ticks(10);
    chk("small_step", 16'(frnt_spd), 16'd390);
    set_cmds(400, 400, 400, 400);
    ticks(20);
    arm = 1'b0;
    ticks(30);
    chk("stopped_off", 16'(motors_off), 16'd1);
    arm = 1'b1;
    ticks(AWR + 1 + 20);
    arm = 1'b0;
    ticks(6);
    arm = 1'b1;
    ticks(5);
    arm = 1'b0;
    ticks(40);
    arm = 1'b1;
    ticks(2);
    arm = 1'b0;
    ticks(3);
    for (int s = 0; s < 60; s++) begin
      int len;
      arm = $urandom_range(0, 3) != 0;
      set_cmds(rnd_cmd(), rnd_cmd(), rnd_cmd(), rnd_cmd());
      len = int'($urandom_range(1, 80));
      for (int j = 0; j < len; j++) begin
        @(negedge clk);
        if ($urandom_range(0, 15) == 0) frnt_cmd = 11'(rnd_cmd());
      end
    end
    arm = 1'b0;
    ticks(140);
    set_cmds(200, 200, 200, 200);
    arm = 1'b1;
    ticks(AWR + 1 + 13 + 2);
    chk("pre_reset_spd", 16'(lft_spd), 16'd200);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_spd", 16'(frnt_spd | bck_spd | lft_spd | rght_spd), 16'd0);
    chk("async_wrt", 16'(wrt), 16'd0);
    chk("async_motors_off", 16'(motors_off), 16'd1);
    chk("async_armed", 16'(armed), 16'd0);
    @(negedge clk);
    arm = 1'b0;
    rst_n = 1'b1;
    ticks(5);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/motor_cmd_seq.md
# motor_cmd_seq

Arming and slew-rate sequencer that sits directly upstream of the four-motor ESC block. It takes raw per-motor speed commands from the flight controller and produces the `frnt_spd`/`bck_spd`/`lft_spd`/`rght_spd`, `wrt` and `motors_off` signals that the ESC block consumes. It enforces four things: a zero-throttle arming period, a bounded per-update speed change, a controlled ramp-down on disarm, and a fixed-rate `wrt` strobe.

## Interface

Parameters:
- `WRT_PERIOD`, default 50000: clocks between `wrt` pulses; minimum 2.
- `ARM_WRTS`, default 1000: number of `wrt` periods held at zero speed before RUN; minimum 1.
- `MAX_STEP`, default 11'd16: maximum per-`wrt` change of any speed output; minimum 1.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `frnt_cmd`, `bck_cmd`, `lft_cmd`, `rght_cmd`  in  11 each  requested motor speeds, unsigned.
- `arm`  in  1  level arm request, synchronous to `clk`.
- `frnt_spd`, `bck_spd`, `lft_spd`, `rght_spd`  out  11 each  slewed speeds to the ESC block, registered.
- `wrt`  out  1  one-cycle update strobe to the ESC block, registered.
- `motors_off`  out  1  forces ESC speeds to zero, registered.
- `armed`  out  1  high only in RUN, registered.

## Operation

- **Period counter.** Free-running, width `$clog2(WRT_PERIOD)`, counts 0..`WRT_PERIOD`-1 and wraps.
  - `tick` = (count == `WRT_PERIOD`-1).
  - All state, speed and `arm_cnt` updates occur only at a `tick` edge.
- **State OFF** (reset state):
  - Speeds 0, `motors_off`=1, `armed`=0.
  - `arm`=1 at tick → ARMING, `arm_cnt`←0.
- **State ARMING:**
  - Speeds held 0, `motors_off`=0.
  - At each tick with `arm`=1: if `arm_cnt`==`ARM_WRTS`-1 → RUN, else `arm_cnt`++.
  - `arm`=0 at tick → OFF.
- **State RUN:**
  - At each tick, each speed moves toward its cmd by `min(|cmd-spd|, MAX_STEP)`.
  - If equal, the speed holds.
  - Arithmetic is 11-bit unsigned. The difference is computed without wrap (compare first, then subtract larger minus smaller), so results stay in 0..2047.
  - `arm`=0 at tick → STOP. In that same tick the speeds are not slewed and hold their values.
- **State STOP:**
  - At each tick, each speed decreases by `min(spd, MAX_STEP)`. Commands are ignored.
  - If all four speeds are already 0 at the tick → OFF.
  - `arm`=1 at tick → RUN. Slewing toward commands resumes from the current speeds at the next tick; there is no re-arm wait.
- **Priority.** `arm` is evaluated before the zero check. In STOP with `arm`=1 and all speeds zero, the next state is RUN.
- **Outputs by state:**
  - `motors_off`=1 only in OFF.
  - `armed`=1 only in RUN.
  - `wrt` pulses in every state, including OFF.
- **Reset.** Assertion at any time immediately forces:
  - count=0, state OFF, `arm_cnt`=0;
  - all speeds 0;
  - `wrt`=0, `motors_off`=1, `armed`=0.

## Timing

- First `wrt` pulse: `WRT_PERIOD` cycles after the first rising edge with `rst_n` high. After that, exactly one pulse every `WRT_PERIOD` cycles.
- `wrt` is registered from `tick`. The new speed values, the new `motors_off`/`armed`, and `wrt`=1 all appear in the same cycle, directly after the tick edge. The ESC block can therefore sample `SPEED` on `wrt` with no skew.
- Command latency: a cmd or `arm` value is sampled only at a tick edge. It is visible on the outputs the next cycle, and changes between ticks are ignored.
- Arming: with `arm` held high, RUN is entered at the (`ARM_WRTS`+1)-th tick counted from the tick that leaves OFF. The first nonzero speed appears on that same tick.
- Ramp time: reaching target T from 0 takes `ceil(T/MAX_STEP)` ticks in RUN. The same count applies for STOP reaching 0.

## Test plan

Bench parameters: `WRT_PERIOD`=8, `ARM_WRTS`=3, `MAX_STEP`=16.

- **Reset and idle.** Release reset with `arm`=0 → `wrt` high exactly at cycles 8, 16, 24…, width 1; `motors_off`=1, all speeds 0, `armed`=0.
- **Arm and ramp up.** `arm`=1, all cmds=400 → `motors_off`=0 after the 1st tick; speeds stay 0 through ARMING. Speeds then go 16, 32, … and reach 400 exactly 25 ticks into RUN; `armed`=1 and `wrt` coincides with each update.
- **Small step and per-motor independence.** In RUN at 400, set `frnt_cmd`=390 and `bck_cmd`=2047 → `frnt_spd`=390 after one tick; `bck_spd` rises by 16 per tick with no overflow.
- **Disarm ramp-down.** Drop `arm` at 400 → STOP, speeds fall by 16 per tick to 0 over 25 ticks. OFF follows at the next tick with `motors_off`=1; re-raising `arm` mid-STOP returns to RUN immediately.
- **Abort during arming.** `arm` drops after 1 ARMING tick → OFF at the next tick; speeds never leave 0.
- **Reset mid-RUN.** With speeds at 200, pulse `rst_n` low mid-period → outputs are 0/0/1/0 immediately, asynchronously. After release, the `wrt` cadence restarts from count 0.
